// File: rtl/chacha_block_core.sv
// ChaCha block function: 16x32-bit state, iterative column/diagonal rounds with LANES
// quarter-rounds per cycle, optional feed-forward into a separate byte-readable result buffer.
module chacha_block_core #(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned LANES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [5:0] addr,
  input  logic       wr_en,
  input  logic       start,
  input  logic       raw_mode,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done
);

  localparam int unsigned Steps = 4 / LANES;

  typedef enum logic [1:0] {StIdle, StRun, StFeed, StDone} state_e;
  typedef struct packed {logic [31:0] a, b, c, d;} qr_t;

  state_e      state_q, state_d;
  logic [31:0] in_q  [16];
  logic [31:0] w_q   [16];
  logic [31:0] w_rnd [16];
  logic [31:0] res_q [16];
  logic        raw_q;
  logic [4:0]  round_q;
  logic [1:0]  step_q;
  logic        step_last, round_last, diag;
  logic [1:0]  lane_grp [LANES];
  qr_t         lane_out [LANES];

  function automatic qr_t quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Word index of position pos (0=a..3=d) in group grp; diagonals rotate the column by pos.
  function automatic logic [3:0] gidx(input logic dg, input logic [1:0] grp,
                                      input logic [1:0] pos);
    return {pos, dg ? grp + pos : grp};
  endfunction

  assign step_last  = (step_q == 2'(Steps - 1));
  assign round_last = (round_q == 5'(ROUNDS - 1));
  assign diag       = round_q[0];

  // Groups within a round are disjoint, so every lane reads the pre-step state.
  always_comb begin
    w_rnd = w_q;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_grp[l] = 2'(int'(step_q) * int'(LANES) + l);
      lane_out[l] = quarter_round(w_q[gidx(diag, lane_grp[l], 2'd0)],
                                  w_q[gidx(diag, lane_grp[l], 2'd1)],
                                  w_q[gidx(diag, lane_grp[l], 2'd2)],
                                  w_q[gidx(diag, lane_grp[l], 2'd3)]);
      w_rnd[gidx(diag, lane_grp[l], 2'd0)] = lane_out[l].a;
      w_rnd[gidx(diag, lane_grp[l], 2'd1)] = lane_out[l].b;
      w_rnd[gidx(diag, lane_grp[l], 2'd2)] = lane_out[l].c;
      w_rnd[gidx(diag, lane_grp[l], 2'd3)] = lane_out[l].d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !wr_en) state_d = StRun;
      StRun:   if (step_last && round_last) state_d = StFeed;
      StFeed:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun) || (state_q == StFeed);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        in_q[i]  <= '0;
        w_q[i]   <= '0;
        res_q[i] <= '0;
      end
      raw_q   <= 1'b0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      if (wr_en && (state_q == StIdle || state_q == StDone)) begin
        in_q[addr[5:2]][{addr[1:0], 3'b000} +: 8] <= din;
      end
      if (state_q == StIdle && start && !wr_en) begin
        w_q     <= in_q;
        raw_q   <= raw_mode;
        round_q <= '0;
        step_q  <= '0;
      end
      if (state_q == StRun) begin
        w_q <= w_rnd;
        if (step_last) begin
          step_q  <= '0;
          round_q <= round_q + 5'd1;
        end else begin
          step_q <= step_q + 2'd1;
        end
      end
      if (state_q == StFeed) begin
        for (int i = 0; i < 16; i++) begin
          res_q[i] <= raw_q ? w_q[i] : w_q[i] + in_q[i];
        end
      end
    end
  end

  assign dout = res_q[addr[5:2]][{addr[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 vectors, lane variants, raw mode,
// ignored writes/starts while busy, and reset mid-computation.
module tb_chacha_block_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [5:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       start = 1'b0;
  logic       raw_mode = 1'b0;
  logic [7:0] dout1, dout2, dout4;
  logic       busy1, busy2, busy4;
  logic       done1, done2, done4;

  int n_tests = 0;
  int n_fail  = 0;
  int bc1, bc2, bc4, dc1, dc2, dc4;
  logic [31:0] cur_in [16];
  logic [31:0] res_a1 [16];

  always #5 clk = ~clk;

  chacha_block_core #(.ROUNDS(20), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .start(start),
    .raw_mode(raw_mode), .dout(dout1), .busy(busy1), .done(done1)
  );
  chacha_block_core #(.ROUNDS(20), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .start(start),
    .raw_mode(raw_mode), .dout(dout2), .busy(busy2), .done(done2)
  );
  chacha_block_core #(.ROUNDS(20), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .start(start),
    .raw_mode(raw_mode), .dout(dout4), .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cur();
    for (int w = 0; w < 16; w++) begin
      for (int b = 0; b < 4; b++) begin
        wr_en = 1'b1;
        addr  = 6'(w * 4 + b);
        din   = cur_in[w][8*b +: 8];
        tick();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int sel, input int idx, output logic [31:0] v);
    for (int b = 0; b < 4; b++) begin
      addr = 6'(idx * 4 + b);
      #1;
      v[8*b +: 8] = (sel == 1) ? dout1 : (sel == 2) ? dout2 : dout4;
    end
  endtask

  task automatic set_consts();
    cur_in[0] = 32'h61707865;
    cur_in[1] = 32'h3320646e;
    cur_in[2] = 32'h79622d32;
    cur_in[3] = 32'h6b206574;
  endtask

  task automatic set_a1();
    for (int i = 0; i < 16; i++) cur_in[i] = '0;
    set_consts();
  endtask

  task automatic set_rfc232();
    set_consts();
    for (int k = 0; k < 8; k++) begin
      cur_in[4+k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    end
    cur_in[12] = 32'h00000001;
    cur_in[13] = 32'h09000000;
    cur_in[14] = 32'h4a000000;
    cur_in[15] = 32'h00000000;
  endtask

  // Pulse start, then watch a fixed window long enough for every lane variant to finish.
  task automatic run_all(input logic raw, input bit midrun);
    raw_mode = raw;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    raw_mode = 1'b0;
    bc1 = 0; bc2 = 0; bc4 = 0; dc1 = 0; dc2 = 0; dc4 = 0;
    for (int c = 0; c < 90; c++) begin
      if (midrun && c == 5) begin
        addr = 6'd0;
        #1;
        n_tests++;
        if (dout1 !== 8'h10) begin
          n_fail++;
          $display("FAIL res_stable_busy: got %h expected 10", dout1);
        end
        wr_en = 1'b1;
        din   = 8'hff;
        start = 1'b1;
      end else if (midrun && c == 6) begin
        wr_en = 1'b0;
        start = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      bc1 += int'(busy1); bc2 += int'(busy2); bc4 += int'(busy4);
      dc1 += int'(done1); dc2 += int'(done2); dc4 += int'(done4);
      tick();
    end
  endtask

  task automatic check_rfc232_words(input string tag);
    logic [31:0] exp [4];
    logic [31:0] w;
    exp[0] = 32'he4e7f110; exp[1] = 32'h15593bd1; exp[2] = 32'h1fdd0f50; exp[3] = 32'hc47120a3;
    for (int i = 0; i < 4; i++) begin
      read_word(1, i, w);
      n_tests++;
      if (w !== exp[i]) begin
        n_fail++;
        $display("FAIL %s word%0d: got %h expected %h", tag, i, w, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy1, done1);
    end
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      n_tests++;
      if (dout1 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout[%0d]: got %h expected 00", a, dout1);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] w;
    run_all(1'b0, 1'b0);
    n_tests++;
    if (bc1 !== 81 || dc1 !== 1) begin
      n_fail++;
      $display("FAIL zero_timing: got busy=%0d done=%0d expected 81 1", bc1, dc1);
    end
    for (int i = 0; i < 16; i++) begin
      read_word(1, i, w);
      n_tests++;
      if (w !== 32'h0) begin
        n_fail++;
        $display("FAIL zero_res[%0d]: got %h expected 00000000", i, w);
      end
    end
  endtask

  task automatic test_rfc232();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h10; exp_b[1] = 8'hf1; exp_b[2] = 8'he7; exp_b[3] = 8'he4;
    set_rfc232();
    load_cur();
    run_all(1'b0, 1'b0);
    n_tests++;
    if (bc1 !== 81 || dc1 !== 1) begin
      n_fail++;
      $display("FAIL rfc232_timing: got busy=%0d done=%0d expected 81 1", bc1, dc1);
    end
    check_rfc232_words("rfc232");
    for (int a = 0; a < 4; a++) begin
      addr = 6'(a);
      #1;
      n_tests++;
      if (dout1 !== exp_b[a]) begin
        n_fail++;
        $display("FAIL rfc232_byte%0d: got %h expected %h", a, dout1, exp_b[a]);
      end
    end
  endtask

  task automatic test_mid_run();
    logic [31:0] w0, w1;
    set_a1();
    load_cur();
    run_all(1'b0, 1'b1);
    n_tests++;
    if (bc1 !== 81 || dc1 !== 1) begin
      n_fail++;
      $display("FAIL midrun_timing: got busy=%0d done=%0d expected 81 1", bc1, dc1);
    end
    read_word(1, 0, w0);
    read_word(1, 1, w1);
    n_tests++;
    if (w0 !== 32'hade0b876 || w1 !== 32'h903df1a0) begin
      n_fail++;
      $display("FAIL midrun_res: got %h %h expected ade0b876 903df1a0", w0, w1);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] w;
    set_a1();
    load_cur();
    run_all(1'b0, 1'b0);
    n_tests++;
    if (bc1 !== 81 || bc2 !== 41 || bc4 !== 21) begin
      n_fail++;
      $display("FAIL lanes_busy: got %0d %0d %0d expected 81 41 21", bc1, bc2, bc4);
    end
    n_tests++;
    if (dc1 !== 1 || dc2 !== 1 || dc4 !== 1) begin
      n_fail++;
      $display("FAIL lanes_done: got %0d %0d %0d expected 1 1 1", dc1, dc2, dc4);
    end
    for (int i = 0; i < 16; i++) read_word(1, i, res_a1[i]);
    n_tests++;
    if (res_a1[0] !== 32'hade0b876 || res_a1[1] !== 32'h903df1a0) begin
      n_fail++;
      $display("FAIL a1_res: got %h %h expected ade0b876 903df1a0", res_a1[0], res_a1[1]);
    end
    for (int i = 0; i < 16; i++) begin
      read_word(2, i, w);
      n_tests++;
      if (w !== res_a1[i]) begin
        n_fail++;
        $display("FAIL lanes2_res[%0d]: got %h expected %h", i, w, res_a1[i]);
      end
      read_word(4, i, w);
      n_tests++;
      if (w !== res_a1[i]) begin
        n_fail++;
        $display("FAIL lanes4_res[%0d]: got %h expected %h", i, w, res_a1[i]);
      end
    end
  endtask

  task automatic test_raw();
    logic [31:0] w;
    run_all(1'b1, 1'b0);
    n_tests++;
    if (bc1 !== 81 || dc1 !== 1) begin
      n_fail++;
      $display("FAIL raw_timing: got busy=%0d done=%0d expected 81 1", bc1, dc1);
    end
    read_word(1, 0, w);
    n_tests++;
    if (w !== 32'h4c704011) begin
      n_fail++;
      $display("FAIL raw_word0: got %h expected 4c704011", w);
    end
    read_word(1, 1, w);
    n_tests++;
    if (w !== 32'h5d1d8d32) begin
      n_fail++;
      $display("FAIL raw_word1: got %h expected 5d1d8d32", w);
    end
    for (int i = 0; i < 16; i++) begin
      read_word(1, i, w);
      n_tests++;
      if (w + cur_in[i] !== res_a1[i]) begin
        n_fail++;
        $display("FAIL raw_ff[%0d]: got %h expected %h", i, w + cur_in[i], res_a1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_rfc232();
    cur_in[0] = 32'h61707800;
    load_cur();
    // Write and start together: only the write lands.
    wr_en = 1'b1;
    start = 1'b1;
    addr  = 6'd0;
    din   = 8'h65;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_start_busy: got %b expected 0", busy1);
    end
    tick();
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_start_busy2: got %b expected 0", busy1);
    end
    run_all(1'b0, 1'b0);
    check_rfc232_words("wr_start");
    run_all(1'b0, 1'b0);
    n_tests++;
    if (bc1 !== 81 || dc1 !== 1) begin
      n_fail++;
      $display("FAIL b2b_timing: got busy=%0d done=%0d expected 81 1", bc1, dc1);
    end
    check_rfc232_words("b2b");
  endtask

  task automatic test_rst_mid_run();
    int nz;
    set_a1();
    load_cur();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got busy=%b done=%b expected 0 0", busy1, done1);
    end
    nz = 0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      if (dout1 !== 8'h00) nz++;
    end
    n_tests++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_dout: got %0d nonzero bytes expected 0", nz);
    end
    bc1 = 0;
    dc1 = 0;
    for (int c = 0; c < 90; c++) begin
      bc1 += int'(busy1);
      dc1 += int'(done1);
      tick();
    end
    n_tests++;
    if (bc1 !== 0 || dc1 !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got busy=%0d done=%0d expected 0 0", bc1, dc1);
    end
    set_rfc232();
    load_cur();
    run_all(1'b0, 1'b0);
    check_rfc232_words("after_rst");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_rfc232();
    test_mid_run();
    test_lanes();
    test_raw();
    test_back_to_back();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
- Full ChaCha block function: 16x32-bit state, iterative column/diagonal rounds, optional feed-forward addition.
- Successor to the single-cycle quarter-round block.
- Adds parametrised round count, parallel quarter-round lanes, a start/busy/done handshake, a separate result buffer and a raw (no feed-forward, HChaCha-style) mode.
- Sits behind the chip's byte-wide pin interface; host loads 64 bytes, starts, polls done, reads 64 bytes.

Parameters:
- ROUNDS, 20, total rounds (column + diagonal count as one round each); even, 2..20.
- LANES, 1, quarter-round units evaluated per cycle; 1, 2 or 4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- din  input  8  write data byte
- addr  input  6  byte address: addr[5:2] word index 0..15, addr[1:0] byte within word, little-endian (0 = bits 7:0)
- wr_en  input  1  write din to input-state byte addr
- start  input  1  begin block computation
- raw_mode  input  1  sampled with start; 1 = skip feed-forward
- dout  output  8  result-buffer byte at addr (combinational)
- busy  output  1  computation in progress
- done  output  1  one-cycle pulse, result buffer valid

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Storage: input state IN[16], working state W[16], result buffer RES[16], all 32-bit. Reset clears all to 0, FSM to IDLE, busy=0, done=0, raw latch=0.
- FSM states:
  - IDLE, start=1 and wr_en=0: W<=IN, latch raw_mode, clear round/step counters -> RUN.
  - RUN: each cycle applies LANES quarter-rounds to W. After 4/LANES cycles a round completes, and rounds alternate column then diagonal. After ROUNDS*4/LANES cycles -> FEED.
  - FEED, one cycle: RES[i] <= raw ? W[i] : W[i]+IN[i] (mod 2^32) -> DONE.
  - DONE, one cycle: done=1 -> IDLE.
- busy=1 in RUN and FEED, else 0.
- Latency: start sampled on edge 0; busy high for ROUNDS*4/LANES+1 cycles; done high the following cycle. ROUNDS=20, LANES=1: 81 busy cycles, done on cycle 82.
- Column groups (a,b,c,d): (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
- Diagonal groups: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Groups are processed in listed order, LANES consecutive groups per cycle. The groups in one round are disjoint, so parallel evaluation is exact.
- Quarter-round, all adds mod 2^32, rotations left:
  - a+=b; d^=a; d<<<16
  - c+=d; b^=c; b<<<12
  - a+=b; d^=a; d<<<8
  - c+=d; b^=c; b<<<7
- Writes: in IDLE or DONE, wr_en updates one byte of IN only. wr_en while busy is ignored.
- wr_en and start in the same cycle: write performed, start ignored.
- start while busy or in DONE: ignored.
- Reads: dout = RES byte at addr at all times. RES is stable while busy and holds the previous result; it changes only in FEED.
- IN is unchanged by computation, so back-to-back starts recompute the same block. Host increments the counter word by rewriting bytes.
- rst mid-RUN/FEED: immediate return to IDLE, all state cleared, no done pulse.

Test Plan:
- Reset, then read all 64 addrs -> dout=0x00, busy=0, done=0. Start with IN all-zero, raw=0 -> busy 81 cycles, done single pulse, RES all zero (zero is a quarter-round fixed point).
- RFC 8439 §2.3.2 vector: constants 61707865 3320646e 79622d32 6b206574, key bytes 00..1f, counter 1, nonce 00000009 0000004a 00000000; start, raw=0 -> RES words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; addr 0..3 read 10 f1 e7 e4.
- RFC 8439 A.1 vector 1 (constants, key 0, counter 0, nonce 0) -> bytes 0..7 = 76 b8 e0 ad a0 f1 3d 90. Repeat with LANES=2 and LANES=4 -> identical RES; busy 41 and 21 cycles.
- Same vector, raw_mode=1 -> RES[i] equals the earlier result minus IN[i] mod 2^32 for every word.
- Mid-RUN: wr_en to addr 0 and start pulses -> IN, RES and timing unaffected. wr_en+start together in IDLE -> byte written, busy stays 0.
- rst asserted 10 cycles after start -> next cycle busy=0, dout=0x00 everywhere, no done pulse. Subsequent load and start computes correctly.
